sprite_layer_mixer: RTL and testbench

- Downstream of the per-sprite compositors (player, enemies, clouds). Each compositor drives RGB plus a hit flag per pixel.
- Selects the highest-priority opaque layer over a background colour and registers the result for the video output.
- Detects player-vs-other-layer pixel overlap. Overlap results are reported once per frame, at the vertical sync rising edge, for the game FSM.

---
 rtl/sprite_layer_mixer.sv | 182 ++++++++++++++++++
 tb/tb_sprite_layer_mixer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_mixer.sv
// sprite_layer_mixer
//   Two-stage pixel mixer that sits behind the per-sprite compositors.
//   Stage 1 registers every input. Stage 2 selects the highest-priority
//   opaque layer, falling back to the background, and registers the
//   video outputs. Layer 0 is the player and has the highest priority.
//   Player-vs-layer overlaps are accumulated over a frame. They are
//   reported on the rising edge of the registered vertical sync.
//
//   Optional build macro: SPRITE_LAYER_MIXER_BLEND_EN
//     When it is defined, layers 1..N_LAYERS-1 are drawn 50% translucent
//     over the next hit layer beneath them, or over the background if no
//     layer beneath is hit. Layer 0 stays opaque. Latency is unchanged.
//     When it is undefined, the mixer is a pure priority mux.

module sprite_layer_mixer #(
  parameter int N_LAYERS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [15:0]             i_x,
  input  logic [15:0]             i_y,
  input  logic                    i_de,
  input  logic                    i_v_sync,
  input  logic [24*N_LAYERS-1:0]  i_layer_rgb,
  input  logic [N_LAYERS-1:0]     i_layer_hit,
  input  logic [23:0]             i_bg_rgb,
  output logic [7:0]              o_red,
  output logic [7:0]              o_green,
  output logic [7:0]              o_blue,
  output logic [15:0]             o_x,
  output logic [15:0]             o_y,
  output logic                    o_de,
  output logic                    o_collision,
  output logic [N_LAYERS-2:0]     o_collision_mask,
  output logic [CNT_W-1:0]        o_collision_count,
  output logic [CNT_W-1:0]        o_frame_count
);

  localparam int MASK_W = N_LAYERS - 1;

  // Stage 1 registers
  logic [15:0]            s1_x;
  logic [15:0]            s1_y;
  logic                   s1_de;
  logic                   s1_vs;
  logic [24*N_LAYERS-1:0] s1_rgb;
  logic [N_LAYERS-1:0]    s1_hit;
  logic [23:0]            s1_bg;

  // Vertical sync history (the previous value of s1_vs)
  logic                   vs_prev;

  // Collision accumulator for the frame in progress
  logic [MASK_W-1:0]      coll_acc;

  // Combinational stage-2 signals
  logic [23:0]            sel_rgb;
  logic [23:0]            mix_rgb;
  logic [23:0]            pix_rgb;
  logic [MASK_W-1:0]      coll_now;
  logic [MASK_W-1:0]      frame_mask;
  logic                   frame_edge;

`ifdef SPRITE_LAYER_MIXER_BLEND_EN
  logic [23:0]            below_rgb;
  logic [8:0]             sum_r;
  logic [8:0]             sum_g;
  logic [8:0]             sum_b;
`endif

  // Stage 1: register all inputs so that stage 2 works from a stable snapshot
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_x    <= '0;
      s1_y    <= '0;
      s1_de   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_rgb  <= '0;
      s1_hit  <= '0;
      s1_bg   <= '0;
      vs_prev <= 1'b0;
    end else begin
      s1_x    <= i_x;
      s1_y    <= i_y;
      s1_de   <= i_de;
      s1_vs   <= i_v_sync;
      s1_rgb  <= i_layer_rgb;
      s1_hit  <= i_layer_hit;
      s1_bg   <= i_bg_rgb;
      vs_prev <= s1_vs;
    end
  end

  // Priority select: walk from lowest to highest priority so the last hit wins.
  // A layer's colour is read only when its hit flag is set, so don't-care colour
  // data on layers that are not hit never reaches the output.
  always_comb begin
    sel_rgb = s1_bg;
`ifdef SPRITE_LAYER_MIXER_BLEND_EN
    below_rgb = s1_bg;
`endif
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (s1_hit[k]) begin
`ifdef SPRITE_LAYER_MIXER_BLEND_EN
        below_rgb = sel_rgb;
`endif
        sel_rgb = s1_rgb[24*k +: 24];
      end
    end
  end

`ifdef SPRITE_LAYER_MIXER_BLEND_EN
  // Translucent layers: average the winning layer with what lies beneath it,
  // using a 9-bit sum and truncating on the shift back to 8 bits
  always_comb begin
    sum_r = {1'b0, sel_rgb[23:16]} + {1'b0, below_rgb[23:16]};
    sum_g = {1'b0, sel_rgb[15:8]}  + {1'b0, below_rgb[15:8]};
    sum_b = {1'b0, sel_rgb[7:0]}   + {1'b0, below_rgb[7:0]};
    if (s1_hit[0] || (s1_hit == '0)) begin
      mix_rgb = sel_rgb;
    end else begin
      mix_rgb = {sum_r[8:1], sum_g[8:1], sum_b[8:1]};
    end
  end
`else
  // Opaque build: the priority winner goes straight through
  always_comb begin
    mix_rgb = sel_rgb;
  end
`endif

  // Blank outside the visible area, and gather this cycle's collisions and frame edge
  always_comb begin
    pix_rgb    = s1_de ? mix_rgb : 24'h000000;
    coll_now   = (s1_de && s1_hit[0]) ? s1_hit[N_LAYERS-1:1] : '0;
    frame_edge = s1_vs & ~vs_prev;
    frame_mask = coll_acc | coll_now;
  end

  // Stage 2: video outputs aligned with their coordinates
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
      o_x     <= '0;
      o_y     <= '0;
      o_de    <= 1'b0;
    end else begin
      o_red   <= pix_rgb[23:16];
      o_green <= pix_rgb[15:8];
      o_blue  <= pix_rgb[7:0];
      o_x     <= s1_x;
      o_y     <= s1_y;
      o_de    <= s1_de;
    end
  end

  // Per-frame collision reporting: accumulate between edges, publish and clear on an edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      coll_acc          <= '0;
      o_collision       <= 1'b0;
      o_collision_mask  <= '0;
      o_collision_count <= '0;
      o_frame_count     <= '0;
    end else if (frame_edge) begin
      coll_acc         <= '0;
      o_collision_mask <= frame_mask;
      o_collision      <= (frame_mask != '0);
      if ((frame_mask != '0) && (o_collision_count != {CNT_W{1'b1}})) begin
        o_collision_count <= o_collision_count + CNT_W'(1);
      end
      o_frame_count <= o_frame_count + CNT_W'(1);
    end else begin
      coll_acc    <= frame_mask;
      o_collision <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Testbench for sprite_layer_mixer.
// The counters are built narrow (CNT_W = 8) so that saturation and wrap are
// reached in a few hundred frames. Expected outputs come from a pixel/frame
// model. Its results pass through a two-entry queue that matches the mixer latency.
module tb_sprite_layer_mixer;

  localparam int N     = 4;
  localparam int CW    = 8;
  localparam int OUT_W = 24 + 16 + 16 + 1 + 1 + (N - 1) + CW + CW;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             i_rst;
  logic [15:0]      i_x;
  logic [15:0]      i_y;
  logic             i_de;
  logic             i_v_sync;
  logic [24*N-1:0]  i_layer_rgb;
  logic [N-1:0]     i_layer_hit;
  logic [23:0]      i_bg_rgb;
  logic [7:0]       o_red;
  logic [7:0]       o_green;
  logic [7:0]       o_blue;
  logic [15:0]      o_x;
  logic [15:0]      o_y;
  logic             o_de;
  logic             o_collision;
  logic [N-2:0]     o_collision_mask;
  logic [CW-1:0]    o_collision_count;
  logic [CW-1:0]    o_frame_count;

  always #5 clk = ~clk;

  sprite_layer_mixer #(.N_LAYERS(N), .CNT_W(CW)) dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_x               (i_x),
    .i_y               (i_y),
    .i_de              (i_de),
    .i_v_sync          (i_v_sync),
    .i_layer_rgb       (i_layer_rgb),
    .i_layer_hit       (i_layer_hit),
    .i_bg_rgb          (i_bg_rgb),
    .o_red             (o_red),
    .o_green           (o_green),
    .o_blue            (o_blue),
    .o_x               (o_x),
    .o_y               (o_y),
    .o_de              (o_de),
    .o_collision       (o_collision),
    .o_collision_mask  (o_collision_mask),
    .o_collision_count (o_collision_count),
    .o_frame_count     (o_frame_count)
  );

  wire [OUT_W-1:0] obs = {o_red, o_green, o_blue, o_x, o_y, o_de, o_collision,
                          o_collision_mask, o_collision_count, o_frame_count};

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] exp_cur;
  logic [N-2:0]     m_acc;
  logic [N-2:0]     m_mask;
  int               m_ccount;
  int               m_fcount;
  bit               m_prev_vs;

  // Expected pixel colour, computed from the layer rules
  function automatic logic [23:0] ref_pixel(input logic de, input logic [N-1:0] hit,
                                            input logic [24*N-1:0] rgb, input logic [23:0] bg);
    int win;
    int nb;
    logic [23:0] top;
    logic [23:0] bel;
    logic [23:0] res;
    win = -1;
    nb  = -1;
    for (int k = 0; k < N; k++) if (hit[k] && win < 0) win = k;
    if (!de) begin
      res = 24'h0;
    end else if (win < 0) begin
      res = bg;
    end else begin
      top = rgb[24*win +: 24];
      res = top;
`ifdef SPRITE_LAYER_MIXER_BLEND_EN
      if (win > 0) begin
        for (int j = win + 1; j < N; j++) if (hit[j] && nb < 0) nb = j;
        bel = (nb < 0) ? bg : rgb[24*nb +: 24];
        for (int c = 0; c < 3; c++)
          res[8*c +: 8] = 8'((int'(top[8*c +: 8]) + int'(bel[8*c +: 8])) / 2);
      end
`endif
    end
    return res;
  endfunction

  // Apply the current inputs for one clock and update the expected output
  task automatic step();
    logic [23:0]  rgb;
    logic [N-2:0] coll;
    logic         pulse;
    logic [N-2:0] m;
    if (i_rst) begin
      m_acc = '0; m_mask = '0; m_ccount = 0; m_fcount = 0; m_prev_vs = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      exp_q.push_back('0);
      exp_cur = '0;
    end else begin
      rgb   = ref_pixel(i_de, i_layer_hit, i_layer_rgb, i_bg_rgb);
      coll  = (i_de && i_layer_hit[0]) ? i_layer_hit[N-1:1] : '0;
      pulse = 1'b0;
      if (i_v_sync && !m_prev_vs) begin
        m      = m_acc | coll;
        m_mask = m;
        pulse  = (m != '0);
        if (pulse && m_ccount < CMAX) m_ccount++;
        m_fcount = (m_fcount + 1) % (CMAX + 1);
        m_acc  = '0;
      end else begin
        m_acc = m_acc | coll;
      end
      m_prev_vs = i_v_sync;
      exp_q.push_back({rgb, i_x, i_y, i_de, pulse, m_mask, CW'(m_ccount), CW'(m_fcount)});
      @(posedge clk); #1;
      exp_cur = exp_q.pop_front();
    end
  endtask

  task automatic set_idle();
    i_x = 16'($urandom); i_y = 16'($urandom); i_de = 1'b0; i_v_sync = 1'b0;
    i_layer_hit = '0; i_bg_rgb = 24'($urandom);
    for (int k = 0; k < N; k++) i_layer_rgb[24*k +: 24] = 24'($urandom);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    i_de = 1'b1; i_layer_hit = 4'b0111; i_v_sync = 1'b0;
    i_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h want 0", obs);
      end
    end
    i_rst = 1'b0;
  endtask

  task automatic test_priority();
    logic [N-1:0]  hits [6] = '{4'b0000, 4'b0110, 4'b0100, 4'b0110, 4'b0001, 4'b1000};
    logic          des  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    set_idle();
    i_bg_rgb = 24'h102030;
    i_layer_rgb[24*1 +: 24] = 24'hFF0000;
    i_layer_rgb[24*2 +: 24] = 24'h00FF00;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        i_layer_hit = hits[i]; i_de = des[i];
      end else begin
        i_layer_hit = '0; i_de = 1'b0;
      end
      i_x = 16'(100 + i); i_y = 16'(7 * i);
      step();
      checks++;
      if (obs !== exp_cur) begin
        errors++;
        $display("FAIL priority[%0d]: got %h want %h", i, obs, exp_cur);
      end
      if (i == 1) begin
        checks++;
        if ({o_red, o_green, o_blue, o_x, o_y} !== {24'h102030, 16'd100, 16'd0}) begin
          errors++;
          $display("FAIL bg_pixel: got %h%h%h x=%0d y=%0d want 102030 x=100 y=0",
                   o_red, o_green, o_blue, o_x, o_y);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      i_x = 16'($urandom); i_y = 16'($urandom);
      i_de = ($urandom_range(0, 4) != 0);
      i_layer_hit = N'($urandom);
      i_bg_rgb = 24'($urandom);
      for (int k = 0; k < N; k++) i_layer_rgb[24*k +: 24] = 24'($urandom);
      i_v_sync = ($urandom_range(0, 9) == 0);
      step();
      checks++;
      if (obs !== exp_cur) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp_cur);
      end
    end
  endtask

  // One overlapping pixel, then a long v_sync pulse that must report only once
  task automatic run_frame(input string name, input logic de_on, output int pulses);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      set_idle();
      if (i == 0) begin i_de = de_on; i_layer_hit = 4'b0101; end
      i_v_sync = (i >= 2 && i <= 5);
      step();
      if (o_collision) pulses++;
      checks++;
      if (obs !== exp_cur) begin
        errors++;
        $display("FAIL %s[%0d]: got %h want %h", name, i, obs, exp_cur);
      end
    end
  endtask

  task automatic test_collision_frame();
    int pulses;
    do_reset();
    run_frame("collision_frame", 1'b1, pulses);
    checks++;
    if (pulses !== 1 || o_collision_mask !== 3'b010 || o_collision_count !== 8'd1 ||
        o_frame_count !== 8'd1) begin
      errors++;
      $display("FAIL collision_summary: pulses=%0d mask=%b cc=%0d fc=%0d want 1 010 1 1",
               pulses, o_collision_mask, o_collision_count, o_frame_count);
    end
  endtask

  task automatic test_collision_de0();
    int pulses;
    run_frame("collision_de0", 1'b0, pulses);
    checks++;
    if (pulses !== 0 || o_collision_mask !== 3'b000 || o_collision_count !== 8'd1 ||
        o_frame_count !== 8'd2) begin
      errors++;
      $display("FAIL de0_summary: pulses=%0d mask=%b cc=%0d fc=%0d want 0 000 1 2",
               pulses, o_collision_mask, o_collision_count, o_frame_count);
    end
  endtask

  task automatic test_reset_midframe();
    int pulses;
    pulses = 0;
    do_reset();
    set_idle();
    i_de = 1'b1; i_layer_hit = 4'b1011;
    step();
    step();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_idle();
      i_v_sync = (i >= 1);
      step();
      if (o_collision) pulses++;
      checks++;
      if (obs !== exp_cur) begin
        errors++;
        $display("FAIL reset_midframe[%0d]: got %h want %h", i, obs, exp_cur);
      end
    end
    checks++;
    if (pulses !== 0 || o_collision_mask !== 3'b000 || o_frame_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_midframe_summary: pulses=%0d mask=%b fc=%0d want 0 000 1",
               pulses, o_collision_mask, o_frame_count);
    end
  endtask

  task automatic test_counters();
    do_reset();
    for (int f = 0; f < CMAX + 1; f++) begin
      for (int p = 0; p < 2; p++) begin
        set_idle();
        if (p == 0) begin i_de = 1'b1; i_layer_hit = N'($urandom_range(1, 7) * 2 + 1); end
        i_v_sync = (p == 1);
        step();
        checks++;
        if (obs !== exp_cur) begin
          errors++;
          $display("FAIL counters[%0d.%0d]: got %h want %h", f, p, obs, exp_cur);
        end
      end
    end
    set_idle();
    step();
    checks++;
    if (o_collision_count !== 8'hFF || o_frame_count !== 8'h00) begin
      errors++;
      $display("FAIL counters_end: cc=%h fc=%h want ff 00", o_collision_count, o_frame_count);
    end
  endtask

  initial begin
    set_idle();
    i_rst = 1'b1;
    test_reset();
    test_priority();
    test_random();
    test_collision_frame();
    test_collision_de0();
    test_reset_midframe();
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
